// File: rtl/col_parity_checker.sv
// Receive-side column-parity checker: recomputes 5x5 slice column parities, flags mismatching
// columns per slice and counts bad slices per state. Optional macro COL_PARITY_STOP_ON_ERR_EN.
module col_parity_checker #(
  parameter int N     = 25,
  parameter int DEPTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     slice_in,
  input  logic [4:0]       par_in,
  output logic             mismatch_valid,
  output logic             mismatch,
  output logic [4:0]       mismatch_cols,
  output logic [CNT_W-2:0] depth_out,
  output logic [CNT_W-1:0] err_count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [CNT_W-2:0] LAST_DEPTH = (CNT_W-1)'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-2:0] depth_q, depth_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             mv_q, mv_d;
  logic [4:0]       cols_q, cols_d;
  logic [CNT_W-2:0] dout_q, dout_d;

  logic             hs;
  logic [4:0]       cols_now;
  logic             last_slice;

  // Column x lives at bits 24-(x+5y); its parity lands in bit 4-x.
  function automatic logic [4:0] col_parity(input logic [N-1:0] s);
    logic [4:0] p;
    p = '0;
    for (int x = 0; x < 5; x++) begin
      for (int y = 0; y < 5; y++) begin
        p[4-x] = p[4-x] ^ s[24-(x+5*y)];
      end
    end
    return p;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign hs       = in_valid && (state_q == RUN);
  assign cols_now = col_parity(slice_in) ^ par_in;

`ifdef COL_PARITY_STOP_ON_ERR_EN
  assign last_slice = (depth_q == LAST_DEPTH) || (cols_now != 5'd0);
`else
  assign last_slice = (depth_q == LAST_DEPTH);
`endif

  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    err_d   = err_q;
    mv_d    = 1'b0;
    cols_d  = cols_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          depth_d = '0;
          err_d   = '0;
        end
      end
      RUN: begin
        if (hs) begin
          mv_d    = 1'b1;
          cols_d  = cols_now;
          dout_d  = depth_q;
          depth_d = depth_q + 1'b1;
          if (cols_now != 5'd0) err_d = sat_inc(err_q);
          if (last_slice) state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Result registers: one cycle after the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      depth_q <= '0;
      err_q   <= '0;
      mv_q    <= 1'b0;
      cols_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      mv_q    <= mv_d;
      cols_q  <= cols_d;
      dout_q  <= dout_d;
    end
  end

  assign in_ready       = (state_q == RUN);
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == FIN);
  assign mismatch_valid = mv_q;
  assign mismatch_cols  = cols_q;
  assign mismatch       = |cols_q;
  assign depth_out      = dout_q;
  assign err_count      = err_q;

endmodule

// File: tb/tb_col_parity_checker.sv
// Directed + randomized bench for col_parity_checker with a popcount-based reference model.
module tb_col_parity_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] slice_in;
  logic [4:0]  par_in;
  logic        mismatch_valid;
  logic        mismatch;
  logic [4:0]  mismatch_cols;
  logic [5:0]  depth_out;
  logic [6:0]  err_count;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  logic [24:0] sl_arr [64];
  logic [4:0]  pr_arr [64];
  logic [4:0]  obs_cols [64];
  int          exp_err;

`ifdef COL_PARITY_STOP_ON_ERR_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  col_parity_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .slice_in(slice_in), .par_in(par_in), .mismatch_valid(mismatch_valid),
    .mismatch(mismatch), .mismatch_cols(mismatch_cols), .depth_out(depth_out),
    .err_count(err_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Column x consists of bits 24-x, 19-x, 14-x, 9-x, 4-x.
  function automatic logic [4:0] ref_cols(input logic [24:0] s, input logic [4:0] p);
    logic [4:0] c;
    for (int x = 0; x < 5; x++) c[4-x] = ($countones(s & (25'h1084210 >> x)) % 2) == 1;
    return c ^ p;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_rdy"}, in_ready, 0);
    check({tag, "_mv"}, mismatch_valid, 0);
    check({tag, "_mm"}, mismatch, 0);
    check({tag, "_cols"}, mismatch_cols, 0);
    check({tag, "_dep"}, depth_out, 0);
    check({tag, "_err"}, err_count, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // Runs one state from sl_arr/pr_arr; called at a negedge with start low.
  task automatic run_state(input string tag, input bit toggle, input int abort_at,
                           input bit start_in_done);
    int  idx;
    int  cycles;
    bit  finished;
    bit  hs;
    bit  last;
    logic [4:0] ec;
    idx = 0; cycles = 0; finished = 0; exp_err = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_err_clr"}, err_count, 0);
    while (!finished && cycles < 400) begin
      if (abort_at >= 0 && idx == abort_at) begin
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero({tag, "_rst"});
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check({tag, "_rst_done"}, done, 0);
          check({tag, "_rst_busy"}, busy, 0);
          check({tag, "_rst_mv"}, mismatch_valid, 0);
        end
        return;
      end
      check({tag, "_rdy"}, in_ready, 1);
      check({tag, "_busy"}, busy, 1);
      in_valid = toggle ? (cycles % 2 == 0) : 1'b1;
      slice_in = sl_arr[idx];
      par_in   = pr_arr[idx];
      hs = in_valid;
      @(negedge clk);
      cycles++;
      if (hs) begin
        ec = ref_cols(sl_arr[idx], pr_arr[idx]);
        if (ec != 0 && exp_err < 127) exp_err++;
        last = (idx == 63) || (STOP_EN && ec != 0);
        obs_cols[idx] = mismatch_cols;
        check({tag, "_mv"}, mismatch_valid, 1);
        check({tag, "_cols"}, mismatch_cols, ec);
        check({tag, "_mm"}, mismatch, (ec != 0));
        check({tag, "_dep"}, depth_out, idx);
        check({tag, "_errc"}, err_count, exp_err);
        check({tag, "_done"}, done, last);
        idx++;
        finished = last;
      end else begin
        check({tag, "_mv_idle"}, mismatch_valid, 0);
        check({tag, "_done_early"}, done, 0);
      end
    end
    in_valid = 1'b0;
    if (!finished) begin
      check({tag, "_timeout"}, 0, 1);
      return;
    end
    check({tag, "_rdy_fin"}, in_ready, 0);
    if (start_in_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done_after"}, done, 0);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_mv_after"}, mismatch_valid, 0);
    check({tag, "_err_hold"}, err_count, exp_err);
    @(negedge clk);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_err"}, err_count, exp_err);
  endtask

  task automatic fill_clean();
    for (int i = 0; i < 64; i++) begin
      sl_arr[i] = 25'h0;
      pr_arr[i] = 5'h00;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; slice_in = '0; par_in = '0;
    #2;
    check_all_zero("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    fill_clean();
    run_state("clean", 1'b0, -1, 1'b0);
    check("clean_final_err", err_count, 0);

`ifndef COL_PARITY_STOP_ON_ERR_EN
    fill_clean();
    sl_arr[5] = 25'h1000000; pr_arr[5] = 5'b10000;
    run_state("d5_ok", 1'b0, -1, 1'b0);
    check("d5_ok_cols", obs_cols[5], 5'b00000);
    check("d5_ok_err", err_count, 0);

    fill_clean();
    sl_arr[5] = 25'h1000000; pr_arr[5] = 5'b00000;
    run_state("d5_bad", 1'b0, -1, 1'b0);
    check("d5_bad_cols", obs_cols[5], 5'b10000);
    check("d5_bad_err", err_count, 1);

    fill_clean();
    sl_arr[3] = 25'h1F00000;
    sl_arr[8] = 25'h0108421;
    run_state("rowcol", 1'b0, -1, 1'b0);
    check("row0_cols", obs_cols[3], 5'h1F);
    check("col4_cols", obs_cols[8], 5'b00001);
    check("rowcol_err", err_count, 2);

    for (int i = 0; i < 64; i++) begin
      sl_arr[i] = 25'($urandom);
      pr_arr[i] = ref_cols(sl_arr[i], 5'h00) ^ (($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h00);
    end
    run_state("random", 1'b0, -1, 1'b0);

    for (int i = 0; i < 64; i++) begin
      sl_arr[i] = 25'($urandom);
      pr_arr[i] = ref_cols(sl_arr[i], 5'h00) ^ 5'(1 << $urandom_range(0, 4));
    end
    run_state("allbad", 1'b1, -1, 1'b0);
    check("allbad_err64", err_count, 64);

    fill_clean();
    run_state("abort", 1'b0, 30, 1'b0);
    check_all_zero("abort_after");
    fill_clean();
    run_state("after_abort", 1'b0, -1, 1'b0);
    check("after_abort_err", err_count, 0);
`else
    fill_clean();
    sl_arr[10] = 25'h1000000;
    run_state("stop", 1'b0, -1, 1'b1);
    check("stop_depth", depth_out, 10);
    check("stop_err", err_count, 1);
    check("stop_rdy", in_ready, 0);
    check("stop_cols", obs_cols[10], 5'b10000);

    fill_clean();
    run_state("abort", 1'b0, 30, 1'b0);
    check_all_zero("abort_after");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
